sd_clk_ctrl: RTL and testbench

Control-side counterpart of the PLL/DCS SD clock divider. It consumes the PLL lock indication and drives the slow/fast select into the divider. It sequences power-up: wait for lock, settle, then run on the slow clock for identification. It switches to the fast clock only on request, holds oready low while the DCS glitchless switch settles, and falls back to slow if lock is lost. It sits between the SD command/initialisation FSM and clock_divider_pll, in the reference-clock domain.

---
 rtl/sd_clk_ctrl.sv | 128 ++++++++++++
 tb/tb_sd_clk_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sd_clk_ctrl.sv
// sd_clk_ctrl: PLL lock sequencing and slow/fast select for the SD clock divider.
// Ports: iclk, irst | ilocked, ifast_req, iclr_err -> osel_clk, oready, olock_lost.
module sd_clk_ctrl #(
  parameter int LOCK_WAIT   = 1024,
  parameter int SWITCH_WAIT = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic irst,
  input  logic ilocked,
  input  logic ifast_req,
  input  logic iclr_err,
  output logic osel_clk,
  output logic oready,
  output logic olock_lost
);

  localparam int MAXW =
    (LOCK_WAIT > SWITCH_WAIT) ? LOCK_WAIT : SWITCH_WAIT;
  localparam int CW = $clog2(MAXW + 1);

  localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] SW_LD   = CW'(SWITCH_WAIT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    STABLE,
    SWITCH
  } state_t;

  state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync;
  logic lock_s;
  logic sel_n, rdy_n, lost_n;

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge iclk) begin
    if (irst) begin
      sync       <= '0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      osel_clk   <= 1'b0;
      oready     <= 1'b0;
      olock_lost <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], ilocked};
      state      <= state_n;
      cnt        <= cnt_n;
      osel_clk   <= sel_n;
      oready     <= rdy_n;
      olock_lost <= lost_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = osel_clk;
    rdy_n   = oready;
    // a loss detected below overrides the clear
    lost_n  = olock_lost & ~iclr_err;
    unique case (state)
      WAIT_LOCK: begin
        sel_n = 1'b0;
        rdy_n = 1'b0;
        if (lock_s) begin
          state_n = SETTLE;
          cnt_n   = LOCK_LD;
        end
      end
      SETTLE: begin
        sel_n = 1'b0;
        rdy_n = 1'b0;
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          lost_n  = 1'b1;
        end else if (cnt == '0) begin
          state_n = STABLE;
          rdy_n   = 1'b1;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          sel_n   = 1'b0;
          rdy_n   = 1'b0;
          lost_n  = 1'b1;
        end else if (ifast_req != osel_clk) begin
          state_n = SWITCH;
          cnt_n   = SW_LD;
          sel_n   = ifast_req;
          rdy_n   = 1'b0;
        end else begin
          rdy_n = 1'b1;
        end
      end
      SWITCH: begin
        rdy_n = 1'b0;
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
          sel_n   = 1'b0;
          lost_n  = 1'b1;
        end else if (cnt == '0) begin
          state_n = STABLE;
          rdy_n   = 1'b1;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
        sel_n   = 1'b0;
        rdy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// tb_sd_clk_ctrl: directed bench for sd_clk_ctrl.
// Checks {osel_clk,oready,olock_lost} against hand-derived values.
module tb_sd_clk_ctrl;

  logic clk = 1'b0;
  logic rst, locked, fast, clr;
  logic sel, rdy, lost;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sd_clk_ctrl #(
    .LOCK_WAIT  (8),
    .SWITCH_WAIT(4),
    .SYNC_STAGES(2)
  ) dut (
    .iclk      (clk),
    .irst      (rst),
    .ilocked   (locked),
    .ifast_req (fast),
    .iclr_err  (clr),
    .osel_clk  (sel),
    .oready    (rdy),
    .olock_lost(lost)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [2:0] exp);
    logic [2:0] obs;
    obs = {sel, rdy, lost};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: sel/rdy/lost observed=%b expected=%b",
                tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0;
    fast = 1'b0; clr = 1'b0;
    step(3);
    check("reset", 3'b000);
    rst = 1'b0;

    // 1: power-up sequence
    step(10);
    locked = 1'b1;
    step(10);
    check("pwr_not_yet", 3'b000);
    step(1);
    check("pwr_ready", 3'b010);

    // 2: slow->fast->slow
    fast = 1'b1;
    step(1);
    check("sw_fast_start", 3'b100);
    step(3);
    check("sw_fast_hold", 3'b100);
    step(1);
    check("sw_fast_done", 3'b110);
    fast = 1'b0;
    step(1);
    check("sw_slow_start", 3'b000);
    step(3);
    check("sw_slow_hold", 3'b000);
    step(1);
    check("sw_slow_done", 3'b010);

    // 3: request toggled during SWITCH
    fast = 1'b1;
    step(1);
    check("tog_start", 3'b100);
    fast = 1'b0;
    step(3);
    check("tog_hold", 3'b100);
    step(1);
    check("tog_pulse", 3'b110);
    step(1);
    check("tog_back", 3'b000);
    step(3);
    check("tog_back_hold", 3'b000);
    step(1);
    check("tog_back_done", 3'b010);

    // 4: lock loss while fast
    fast = 1'b1;
    step(5);
    check("fast_ready", 3'b110);
    locked = 1'b0;
    step(2);
    check("loss_in_sync", 3'b110);
    step(1);
    check("loss_fallback", 3'b001);
    locked = 1'b1;
    step(10);
    check("relock_settle", 3'b001);
    step(1);
    check("relock_ready", 3'b011);
    step(1);
    check("relock_to_fast", 3'b101);
    step(4);
    check("relock_fast_rdy", 3'b111);

    // 5: glitch in SETTLE, error clearing
    fast = 1'b0;
    step(5);
    check("back_slow", 3'b011);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_alone", 3'b010);
    locked = 1'b0;
    step(3);
    check("drop_again", 3'b001);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_in_wait", 3'b000);
    locked = 1'b1;
    step(6);
    check("settle_mid", 3'b000);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(2);
    check("glitch_lost", 3'b001);
    step(8);
    check("settle_restart", 3'b001);
    step(1);
    check("glitch_ready", 3'b011);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_pulse", 3'b010);
    locked = 1'b0;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_vs_loss", 3'b001);

    // 6: reset during SWITCH
    locked = 1'b1;
    step(11);
    check("pre_sw_ready", 3'b011);
    fast = 1'b1;
    step(2);
    check("in_switch", 3'b101);
    rst = 1'b1;
    step(1);
    check("rst_in_switch", 3'b000);
    rst = 1'b0;
    step(10);
    check("post_rst_wait", 3'b000);
    step(1);
    check("post_rst_ready", 3'b010);
    step(1);
    check("post_rst_fast", 3'b100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
